// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked write arbiter in front of a single FIFO write port.
// Producers use valid/ready; the granted producer's words go straight to the
// FIFO, up to BURST words per grant, with same-cycle re-arbitration on release.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_wfull,
    output logic                    fifo_winc,
    output logic [WIDTH-1:0]        fifo_wdata,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [CNTW-1:0]         wcount
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW   = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   grant_q;
    logic [IDXW-1:0]   gidx_q;
    logic [IDXW-1:0]   rr_ptr_q;
    logic [BW-1:0]     beat_q;
    logic [CNTW-1:0]   wcount_q, wcount_d;

    logic              own, g_valid, xfer, rel_a, rel_b, release_w;
    logic [IDXW-1:0]   nxt_ptr, pick_ptr, pick_idx, j_idx;
    logic [NREQ-1:0]   pick_mask;
    logic              pick_found;

    // Handshake and release conditions for the current owner
    always_comb begin
        own       = (state_q == S_OWN);
        g_valid   = |(req_valid & grant_q);
        xfer      = own & g_valid & ~fifo_wfull;
        rel_a     = xfer & (beat_q == BW'(BURST - 1));
        rel_b     = own & ~g_valid;
        release_w = rel_a | rel_b;
        nxt_ptr   = (gidx_q == IDXW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        wcount_d  = wcount_q + CNTW'(xfer);
    end

    // Round-robin pick: from rr_ptr when idle, from owner+1 on release.
    // An owner that dropped valid is masked so it cannot win again this cycle.
    always_comb begin
        pick_ptr   = own ? nxt_ptr : rr_ptr_q;
        pick_mask  = rel_b ? (req_valid & ~grant_q) : req_valid;
        pick_found = 1'b0;
        pick_idx   = '0;
        j_idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            j_idx = IDXW'((int'(pick_ptr) + k) % NREQ);
            if (!pick_found && pick_mask[j_idx]) begin
                pick_found = 1'b1;
                pick_idx   = j_idx;
            end
        end
    end

    // Output steering: only the owner sees ready; data muxed by the one-hot grant
    always_comb begin
        req_ready  = (own && !fifo_wfull) ? grant_q : '0;
        fifo_winc  = xfer;
        fifo_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) fifo_wdata = fifo_wdata | req_data[i*WIDTH +: WIDTH];
        end
        grant  = grant_q;
        busy   = own;
        wcount = wcount_q;
    end

    // Arbitration FSM: IDLE -> OWN on any valid, OWN re-arbitrates without a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        state_q <= S_OWN;
                        grant_q <= NREQ'(1) << pick_idx;
                        gidx_q  <= pick_idx;
                        beat_q  <= '0;
                    end
                end
                S_OWN: begin
                    if (release_w) begin
                        rr_ptr_q <= nxt_ptr;
                        beat_q   <= '0;
                        if (pick_found) begin
                            grant_q <= NREQ'(1) << pick_idx;
                            gidx_q  <= pick_idx;
                        end else begin
                            state_q <= S_IDLE;
                            grant_q <= '0;
                        end
                    end else if (xfer) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Written-word counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) wcount_q <= '0;
        else     wcount_q <= wcount_d;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, BURST=4, CNTW=16).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wfull;
    logic        fifo_winc;
    logic [7:0]  fifo_wdata;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] wcount;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(4), .CNTW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wfull (fifo_wfull),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy),
        .wcount     (wcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] data;
        logic        wfull;
        logic [3:0]  e_grant;
        logic [3:0]  e_ready;
        logic        e_winc;
        logic [7:0]  e_wdata;
        logic        e_busy;
        logic [15:0] e_wc;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic f,
                                logic [3:0] g, logic [3:0] rd, logic w,
                                logic [7:0] wd, logic b, logic [15:0] wc);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.wfull = f;
        t.e_grant = g; t.e_ready = rd; t.e_winc = w; t.e_wdata = wd;
        t.e_busy = b; t.e_wc = wc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset / single requester back-to-back
        tbl[0]  = mk(1, 4'hF, 32'hDEADBEEF, 0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
        tbl[1]  = mk(1, 4'hF, 32'hDEADBEEF, 0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
        tbl[2]  = mk(0, 4'h1, 32'h10,       0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
        tbl[3]  = mk(0, 4'h1, 32'h10,       0, 4'h1, 4'h1, 1, 8'h10, 1, 16'd0);
        tbl[4]  = mk(0, 4'h1, 32'h11,       0, 4'h1, 4'h1, 1, 8'h11, 1, 16'd1);
        tbl[5]  = mk(0, 4'h1, 32'h12,       0, 4'h1, 4'h1, 1, 8'h12, 1, 16'd2);
        tbl[6]  = mk(0, 4'h1, 32'h13,       0, 4'h1, 4'h1, 1, 8'h13, 1, 16'd3);
        tbl[7]  = mk(0, 4'h1, 32'h14,       0, 4'h1, 4'h1, 1, 8'h14, 1, 16'd4);
        tbl[8]  = mk(0, 4'h1, 32'h15,       0, 4'h1, 4'h1, 1, 8'h15, 1, 16'd5);
        tbl[9]  = mk(0, 4'h1, 32'h16,       0, 4'h1, 4'h1, 1, 8'h16, 1, 16'd6);
        tbl[10] = mk(0, 4'h1, 32'h17,       0, 4'h1, 4'h1, 1, 8'h17, 1, 16'd7);
        tbl[11] = mk(0, 4'h0, 32'h0,        0, 4'h1, 4'h1, 0, 8'h00, 1, 16'd8);
        tbl[12] = mk(0, 4'h0, 32'h0,        0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd8);
        // req2 owns, stalled by wfull after its 2nd word
        tbl[13] = mk(0, 4'h4, 32'h00200000, 0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd8);
        tbl[14] = mk(0, 4'h4, 32'h00200000, 0, 4'h4, 4'h4, 1, 8'h20, 1, 16'd8);
        tbl[15] = mk(0, 4'h4, 32'h00210000, 0, 4'h4, 4'h4, 1, 8'h21, 1, 16'd9);
        tbl[16] = mk(0, 4'h4, 32'h00220000, 1, 4'h4, 4'h0, 0, 8'h22, 1, 16'd10);
        tbl[17] = mk(0, 4'h4, 32'h00220000, 1, 4'h4, 4'h0, 0, 8'h22, 1, 16'd10);
        tbl[18] = mk(0, 4'h4, 32'h00220000, 1, 4'h4, 4'h0, 0, 8'h22, 1, 16'd10);
        tbl[19] = mk(0, 4'h4, 32'h00220000, 0, 4'h4, 4'h4, 1, 8'h22, 1, 16'd10);
        tbl[20] = mk(0, 4'hE, 32'h30239900, 0, 4'h4, 4'h4, 1, 8'h23, 1, 16'd11);
        // req3 drops at once; req1 owns and drops after 2 words
        tbl[21] = mk(0, 4'h6, 32'h30244000, 0, 4'h8, 4'h8, 0, 8'h30, 1, 16'd12);
        tbl[22] = mk(0, 4'hE, 32'h30244000, 0, 4'h2, 4'h2, 1, 8'h40, 1, 16'd12);
        tbl[23] = mk(0, 4'hE, 32'h30244100, 0, 4'h2, 4'h2, 1, 8'h41, 1, 16'd13);
        tbl[24] = mk(0, 4'hC, 32'h30240000, 0, 4'h2, 4'h2, 0, 8'h00, 1, 16'd14);
        tbl[25] = mk(0, 4'hC, 32'h30240000, 0, 4'h4, 4'h4, 1, 8'h24, 1, 16'd14);

        rst = 1'b1; req_valid = '0; req_data = '0; fifo_wfull = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; req_valid = tbl[i].vld;
            req_data = tbl[i].data; fifo_wfull = tbl[i].wfull;
            #1;
            chk($sformatf("v%0d.grant", i), 32'(grant),      32'(tbl[i].e_grant));
            chk($sformatf("v%0d.ready", i), 32'(req_ready),  32'(tbl[i].e_ready));
            chk($sformatf("v%0d.winc",  i), 32'(fifo_winc),  32'(tbl[i].e_winc));
            chk($sformatf("v%0d.wdata", i), 32'(fifo_wdata), 32'(tbl[i].e_wdata));
            chk($sformatf("v%0d.busy",  i), 32'(busy),       32'(tbl[i].e_busy));
            chk($sformatf("v%0d.wcnt",  i), 32'(wcount),     32'(tbl[i].e_wc));
            tick();
        end

        // all four valid: rotation 0001,0010,0100,1000,... with 4 words each
        rst = 1'b1; req_valid = '0; fifo_wfull = 1'b0;
        tick();
        rst = 1'b0; req_valid = 4'hF; req_data = 32'hA3A2A1A0;
        #1;
        chk("rr.idle_grant", 32'(grant), 32'h0);
        chk("rr.idle_winc",  32'(fifo_winc), 32'h0);
        tick();
        for (int c = 0; c < 30; c++) begin
            chk($sformatf("rr%0d.grant", c), 32'(grant), 32'(4'b0001 << ((c / 4) % 4)));
            chk($sformatf("rr%0d.winc",  c), 32'(fifo_winc), 32'h1);
            chk($sformatf("rr%0d.wdata", c), 32'(fifo_wdata), 32'(8'hA0 + (c / 4) % 4));
            chk($sformatf("rr%0d.wcnt",  c), 32'(wcount), 32'(c));
            tick();
        end

        // reset pulse in the middle of req3's burst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.busy",  32'(busy),  32'h0);
        chk("rst.ready", 32'(req_ready), 32'h0);
        chk("rst.winc",  32'(fifo_winc), 32'h0);
        chk("rst.wcnt",  32'(wcount), 32'h0);
        tick();
        chk("rst.regrant", 32'(grant), 32'h1);
        chk("rst.winc2",   32'(fifo_winc), 32'h1);
        chk("rst.wcnt2",   32'(wcount), 32'h0);

        // continuous writes up to the counter wrap
        repeat (16'hFFFE) tick();
        chk("wrap.fffe", 32'(wcount), 32'hFFFE);
        tick();
        chk("wrap.ffff", 32'(wcount), 32'hFFFF);
        tick();
        chk("wrap.0000", 32'(wcount), 32'h0000);
        tick();
        chk("wrap.0001", 32'(wcount), 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
